// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with synchronous load, lock-up recovery and
// a measured-period output taken between successive SEED arrivals.
module lfsr_gen #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
  parameter logic [WIDTH-1:0] SEED  = 16'h0145,
  parameter bit              XNOR  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sh_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             max_tick,
  output logic             lockup,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  // The one state the feedback function maps onto itself.
  localparam logic [WIDTH-1:0] LOCK_STATE = XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] step_cnt_reg, step_cnt_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic             max_tick_reg, max_tick_next;
  logic             lockup_reg, lockup_next;
  logic             period_valid_reg, period_valid_next;

  logic [WIDTH-1:0] tap_bits;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] step_inc;
  logic             fb;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tap_bits[gi] = q_reg[gi] & TAPS[gi];
    end
  endgenerate

  assign fb       = (^tap_bits) ^ XNOR;
  assign shifted  = {q_reg[WIDTH-2:0], fb};
  assign step_inc = (step_cnt_reg == ALL_ONES) ? step_cnt_reg : step_cnt_reg + WIDTH'(1);

  always_comb begin
    q_next            = q_reg;
    step_cnt_next     = step_cnt_reg;
    period_next       = period_reg;
    period_valid_next = period_valid_reg;
    max_tick_next     = 1'b0;
    lockup_next       = 1'b0;
    if (load) begin
      q_next            = load_val;
      step_cnt_next     = '0;
      period_valid_next = 1'b0;
    end else if (sh_en) begin
      if (q_reg == LOCK_STATE) begin
        // Recovery restarts the count but keeps the last good measurement.
        q_next        = SEED;
        lockup_next   = 1'b1;
        step_cnt_next = '0;
      end else begin
        q_next = shifted;
        if (shifted == SEED) begin
          max_tick_next     = 1'b1;
          period_next       = step_inc;
          period_valid_next = 1'b1;
          step_cnt_next     = '0;
        end else begin
          step_cnt_next = step_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg            <= SEED;
      step_cnt_reg     <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      max_tick_reg     <= 1'b0;
      lockup_reg       <= 1'b0;
    end else begin
      q_reg            <= q_next;
      step_cnt_reg     <= step_cnt_next;
      period_reg       <= period_next;
      period_valid_reg <= period_valid_next;
      max_tick_reg     <= max_tick_next;
      lockup_reg       <= lockup_next;
    end
  end

  assign q            = q_reg;
  assign max_tick     = max_tick_reg;
  assign lockup       = lockup_reg;
  assign period       = period_reg;
  assign period_valid = period_valid_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default XNOR generator, an XOR variant and a
// 4-bit generator for the multi-period corner cases.
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        d_sh, d_ld, d_mt, d_lk, d_pv;
  logic [15:0] d_val, d_q, d_period;
  logic        x_sh, x_ld, x_mt, x_lk, x_pv;
  logic [15:0] x_val, x_q, x_period;
  logic        n_sh, n_ld, n_mt, n_lk, n_pv;
  logic [3:0]  n_val, n_q, n_period;

  lfsr_gen u_dflt (
    .clk(clk), .reset(reset), .sh_en(d_sh), .load(d_ld), .load_val(d_val),
    .q(d_q), .max_tick(d_mt), .lockup(d_lk), .period(d_period), .period_valid(d_pv)
  );

  lfsr_gen #(.WIDTH(16), .TAPS(16'hD008), .SEED(16'h0145), .XNOR(1'b0)) u_xor (
    .clk(clk), .reset(reset), .sh_en(x_sh), .load(x_ld), .load_val(x_val),
    .q(x_q), .max_tick(x_mt), .lockup(x_lk), .period(x_period), .period_valid(x_pv)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .XNOR(1'b1)) u_nar (
    .clk(clk), .reset(reset), .sh_en(n_sh), .load(n_ld), .load_val(n_val),
    .q(n_q), .max_tick(n_mt), .lockup(n_lk), .period(n_period), .period_valid(n_pv)
  );

  typedef struct {
    logic        ld;
    logic        sh;
    logic [15:0] val;
    logic [15:0] q;
    logic        mt;
    logic        lk;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic vec_t mk(input logic ld, input logic sh, input logic [15:0] val,
                              input logic [15:0] q, input logic mt, input logic lk);
    vec_t v;
    v.ld = ld; v.sh = sh; v.val = val; v.q = q; v.mt = mt; v.lk = lk;
    return v;
  endfunction

  // which: 0 default, 1 xor, 2 narrow. Other instances idle this cycle.
  task automatic step(input int which, input logic ld, input logic sh, input logic [15:0] val);
    d_ld = 1'b0; d_sh = 1'b0; d_val = '0;
    x_ld = 1'b0; x_sh = 1'b0; x_val = '0;
    n_ld = 1'b0; n_sh = 1'b0; n_val = '0;
    case (which)
      0: begin d_ld = ld; d_sh = sh; d_val = val; end
      1: begin x_ld = ld; x_sh = sh; x_val = val; end
      default: begin n_ld = ld; n_sh = sh; n_val = val[3:0]; end
    endcase
    @(posedge clk);
    #1;
  endtask

  vec_t        tbl[13];
  bit          seen[65536];
  int          repeats, ticks, tick_at, idle_ticks, shifts;
  logic [63:0] tick_bits;

  initial begin
    tbl[0]  = mk(1'b0, 1'b1, 16'h0000, 16'h028B, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 16'h0000, 16'h0516, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 16'h0000, 16'h0516, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 16'h0000, 16'h2468, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 16'h0000, 16'h48D0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 16'h0000, 16'h48D0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 16'h0000, 16'h91A0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 16'h0000, 16'h0145, 1'b0, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 16'h0000, 16'h0145, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 16'h0000, 16'h028B, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 16'h0145, 16'h0145, 1'b0, 1'b0);

    d_ld = 1'b0; d_sh = 1'b0; d_val = '0;
    x_ld = 1'b0; x_sh = 1'b0; x_val = '0;
    n_ld = 1'b0; n_sh = 1'b0; n_val = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", d_q, 16'h0145);
    chk("rst_max_tick", d_mt, 1'b0);
    chk("rst_lockup", d_lk, 1'b0);
    chk("rst_period", d_period, 16'h0000);
    chk("rst_period_valid", d_pv, 1'b0);
    chk("rst_nar_q", n_q, 4'h1);
    reset = 1'b0;

    // Directed table on the default generator
    for (int i = 0; i < 13; i++) begin
      step(0, tbl[i].ld, tbl[i].sh, tbl[i].val);
      $display("vec %0d: ld=%0b sh=%0b val=%h -> q=%h mt=%0b lk=%0b pv=%0b",
               i, tbl[i].ld, tbl[i].sh, tbl[i].val, d_q, d_mt, d_lk, d_pv);
      chk($sformatf("tbl%0d_q", i), d_q, tbl[i].q);
      chk($sformatf("tbl%0d_max_tick", i), d_mt, tbl[i].mt);
      chk($sformatf("tbl%0d_lockup", i), d_lk, tbl[i].lk);
      chk($sformatf("tbl%0d_period_valid", i), d_pv, 1'b0);
    end

    // Full period from SEED (step count zeroed by the load above)
    repeats = 0; ticks = 0; tick_at = 0;
    seen[16'h0145] = 1'b1;
    for (int k = 1; k <= 65535; k++) begin
      step(0, 1'b0, 1'b1, 16'h0);
      if (k < 65535) begin
        if (seen[d_q]) repeats++;
        seen[d_q] = 1'b1;
      end
      if (d_mt) begin
        ticks++;
        tick_at = k;
      end
    end
    $display("full run: q=%h period=%0d pv=%0b ticks=%0d at=%0d", d_q, d_period, d_pv, ticks, tick_at);
    chk("full_repeats", repeats, 0);
    chk("full_tick_count", ticks, 1);
    chk("full_tick_at", tick_at, 65535);
    chk("full_q", d_q, 16'h0145);
    chk("full_period", d_period, 16'd65535);
    chk("full_period_valid", d_pv, 1'b1);

    step(0, 1'b0, 1'b1, 16'h0);
    chk("post_full_max_tick", d_mt, 1'b0);
    chk("post_full_q", d_q, 16'h028B);
    step(0, 1'b0, 1'b1, 16'h0);
    step(0, 1'b0, 1'b1, 16'h0);
    chk("hold_period", d_period, 16'd65535);
    chk("hold_period_valid", d_pv, 1'b1);

    // Asynchronous reset mid-run
    #2 reset = 1'b1;
    #1;
    $display("mid reset: q=%h period=%h pv=%0b", d_q, d_period, d_pv);
    chk("midrst_q", d_q, 16'h0145);
    chk("midrst_period", d_period, 16'h0000);
    chk("midrst_period_valid", d_pv, 1'b0);
    chk("midrst_max_tick", d_mt, 1'b0);
    chk("midrst_lockup", d_lk, 1'b0);
    step(0, 1'b0, 1'b1, 16'h0);
    chk("rst_held_q", d_q, 16'h0145);
    reset = 1'b0;
    step(0, 1'b0, 1'b1, 16'h0);
    $display("post reset shift: q=%h", d_q);
    chk("post_rst_q", d_q, 16'h028B);

    // XOR variant: all-zeros lock-up recovery
    step(1, 1'b1, 1'b0, 16'h0000);
    chk("xor_load_q", x_q, 16'h0000);
    chk("xor_load_lockup", x_lk, 1'b0);
    step(1, 1'b0, 1'b1, 16'h0);
    $display("xor recover: q=%h lk=%0b mt=%0b", x_q, x_lk, x_mt);
    chk("xor_rec_q", x_q, 16'h0145);
    chk("xor_rec_lockup", x_lk, 1'b1);
    chk("xor_rec_max_tick", x_mt, 1'b0);
    step(1, 1'b0, 1'b0, 16'h0);
    chk("xor_lockup_clear", x_lk, 1'b0);

    // 4-bit: 45 shifts with idle gaps inserted
    tick_bits = '0; idle_ticks = 0; shifts = 0;
    while (shifts < 45) begin
      if (shifts == 7 || shifts == 22) begin
        for (int g = 0; g < 3; g++) begin
          step(2, 1'b0, 1'b0, 16'h0);
          if (n_mt) idle_ticks++;
        end
      end
      step(2, 1'b0, 1'b1, 16'h0);
      shifts++;
      if (n_mt) tick_bits[shifts] = 1'b1;
    end
    $display("narrow run: q=%h period=%0d pv=%0b ticks=%h", n_q, n_period, n_pv, tick_bits);
    chk("nar_tick_positions", tick_bits, (64'd1 << 15) | (64'd1 << 30) | (64'd1 << 45));
    chk("nar_idle_ticks", idle_ticks, 0);
    chk("nar_period", n_period, 4'd15);
    chk("nar_period_valid", n_pv, 1'b1);
    chk("nar_q", n_q, 4'h1);

    // Load during shift clears period_valid; sequence follows from load value
    step(2, 1'b1, 1'b1, 16'h000A);
    chk("nar_load_q", n_q, 4'hA);
    chk("nar_load_period_valid", n_pv, 1'b0);
    chk("nar_load_period_hold", n_period, 4'd15);
    step(2, 1'b0, 1'b1, 16'h0);
    chk("nar_a1_q", n_q, 4'h4);
    step(2, 1'b0, 1'b1, 16'h0);
    chk("nar_a2_q", n_q, 4'h8);
    step(2, 1'b0, 1'b1, 16'h0);
    chk("nar_a3_q", n_q, 4'h0);
    step(2, 1'b0, 1'b1, 16'h0);
    $display("narrow reload run: q=%h mt=%0b period=%0d pv=%0b", n_q, n_mt, n_period, n_pv);
    chk("nar_a4_q", n_q, 4'h1);
    chk("nar_a4_max_tick", n_mt, 1'b1);
    chk("nar_a4_period", n_period, 4'd4);
    chk("nar_a4_period_valid", n_pv, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
